id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register directly downstream of the instruction decoder's control-signal generator.
- Captures the decoded control bundle (ALU op, branch, memory, write-back, AUIPC/JAL/JALR, halt) together with the operand/immediate/PC data each cycle, and presents it to the EX stage.
- Inserts bubbles on flush, holds on stall, and owns the halt sequencing: request fetch stop, drain the pipe, then assert a sticky halted flag.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC
- HALT_DRAIN, 3, cycles after a Halt instruction enters EX before `cpu_halted` asserts (covers EX/MEM/WB drain); legal range 1..15

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold all registers (hazard unit)
- flush  in  1  replace captured instruction with bubble (branch/jump redirect)
- id_valid  in  1  decode stage holds a real instruction
- id_alu_op  in  2  ALU op class from decode
- id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write, id_auipc, id_jal, id_jalr, id_halt  in  1 each  decoded control
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  datapath values
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_funct3  in  3;  id_funct7b5  in  1  ALU-control selectors
- ex_valid  out  1  EX holds a real instruction
- ex_* (one per id_* input above, same width)  out  registered copies
- halt_req  out  1  tells fetch/decode to stop issuing
- cpu_halted  out  1  sticky: core fully drained and stopped

Behaviour:
- Reset (async, rst_n=0): every output 0; FSM=RUN; drain counter=0. Release is synchronous to the next clk edge.
- Update priority at each posedge: flush > stall > load.
- flush=1: load bubble (ex_valid=0, all ex_ control and data fields 0) regardless of stall.
- stall=1, flush=0: all ex_ registers hold.
- Otherwise: load all ex_ fields from id_ inputs.
  - ex_valid = id_valid.
  - If id_valid=0, control fields are forced to 0 (data fields loaded as-is).
- Latency: 1 cycle from id_ to ex_.
- FSM states RUN, DRAIN, HALTED:
  - RUN -> DRAIN on a load (not stall, not flush) with id_valid=1 and id_halt=1. The same edge asserts halt_req and sets the counter to HALTD_DRAIN-1... precisely: counter := HALT_DRAIN-1.
  - DRAIN: halt_req=1. Counter decrements every cycle, and stall does not pause it. At counter=0 -> HALTED.
  - HALTED: halt_req=1, cpu_halted=1. Every edge loads a bubble (inputs ignored, stall/flush irrelevant). Exits only via reset.
- A flushed or stalled Halt never starts the sequence. A flush arriving during DRAIN or HALTED does not cancel the halt.
- While in DRAIN, further loads are forced to bubbles; the pipe must empty.
- Simultaneous id_halt load and flush: flush wins; stays RUN.
- Reset mid-DRAIN: immediate return to RUN with all outputs 0.
- No arithmetic beyond the counter. The counter is 4 bits; decrement never wraps (guarded at 0).

Test Plan:
- Load: id_valid=1, id_alu_op=2'b10, id_reg_write=1, id_rs1_data=32'h0000_0005, id_rd=5'd3 -> next edge: ex_valid=1, ex_alu_op=2'b10, ex_reg_write=1, ex_rs1_data=5, ex_rd=3.
- Stall hold then flush: load with id_mem_write=1, then stall=1 for 3 cycles with new inputs -> ex_ unchanged. Then stall=1 and flush=1 together -> next edge: ex_valid=0, ex_mem_write=0, all data fields 0.
- Invalid decode: id_valid=0, id_reg_write=1, id_branch=1 -> ex_valid=0, ex_reg_write=0, ex_branch=0.
- Halt drain (HALT_DRAIN=3): load id_halt=1 at edge T -> halt_req=1 from T. cpu_halted=0 at T+1 and T+2, cpu_halted=1 at T+3. Valid inputs after T -> ex_valid=0.
- Flushed halt: id_halt=1 with flush=1 -> halt_req stays 0, FSM stays RUN. A following normal instruction loads correctly.
- Async reset mid-DRAIN: drop rst_n between edges -> halt_req, cpu_halted, ex_valid all 0 immediately, without waiting for clk. After release, normal loads resume.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures the decoded control/data bundle for EX,
// inserts bubbles on flush, holds on stall, and sequences the halt drain.
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int HALT_DRAIN = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [1:0]      id_alu_op,
    input  logic            id_branch,
    input  logic            id_mem_read,
    input  logic            id_mem_to_reg,
    input  logic            id_mem_write,
    input  logic            id_alu_src,
    input  logic            id_reg_write,
    input  logic            id_auipc,
    input  logic            id_jal,
    input  logic            id_jalr,
    input  logic            id_halt,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [2:0]      id_funct3,
    input  logic            id_funct7b5,
    output logic            ex_valid,
    output logic [1:0]      ex_alu_op,
    output logic            ex_branch,
    output logic            ex_mem_read,
    output logic            ex_mem_to_reg,
    output logic            ex_mem_write,
    output logic            ex_alu_src,
    output logic            ex_reg_write,
    output logic            ex_auipc,
    output logic            ex_jal,
    output logic            ex_jalr,
    output logic            ex_halt,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            halt_req,
    output logic            cpu_halted
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic [3:0] DRAIN_INIT = 4'(HALT_DRAIN - 1);

    state_e          state_q;
    logic [3:0]      drain_cnt_q;
    logic            halt_req_q;
    logic            cpu_halted_q;

    logic            capture_s;
    logic            bubble_s;
    logic            ctl_en_s;
    logic            start_halt_s;

    logic            ex_valid_q,      ex_valid_d;
    logic [1:0]      ex_alu_op_q,     ex_alu_op_d;
    logic            ex_branch_q,     ex_branch_d;
    logic            ex_mem_read_q,   ex_mem_read_d;
    logic            ex_mem_to_reg_q, ex_mem_to_reg_d;
    logic            ex_mem_write_q,  ex_mem_write_d;
    logic            ex_alu_src_q,    ex_alu_src_d;
    logic            ex_reg_write_q,  ex_reg_write_d;
    logic            ex_auipc_q,      ex_auipc_d;
    logic            ex_jal_q,        ex_jal_d;
    logic            ex_jalr_q,       ex_jalr_d;
    logic            ex_halt_q,       ex_halt_d;
    logic [XLEN-1:0] ex_pc_q,         ex_pc_d;
    logic [XLEN-1:0] ex_rs1_data_q,   ex_rs1_data_d;
    logic [XLEN-1:0] ex_rs2_data_q,   ex_rs2_data_d;
    logic [XLEN-1:0] ex_imm_q,        ex_imm_d;
    logic [4:0]      ex_rs1_q,        ex_rs1_d;
    logic [4:0]      ex_rs2_q,        ex_rs2_d;
    logic [4:0]      ex_rd_q,         ex_rd_d;
    logic [2:0]      ex_funct3_q,     ex_funct3_d;
    logic            ex_funct7b5_q,   ex_funct7b5_d;

    // Update mode: HALTED always bubbles, then flush > stall > load (bubble while draining).
    always_comb begin
        capture_s = 1'b0;
        bubble_s  = 1'b0;
        if (state_q == ST_HALTED) begin
            bubble_s = 1'b1;
        end else if (flush) begin
            bubble_s = 1'b1;
        end else if (stall) begin
            bubble_s = 1'b0;
        end else if (state_q == ST_DRAIN) begin
            bubble_s = 1'b1;
        end else begin
            capture_s = 1'b1;
        end
        ctl_en_s     = capture_s & id_valid;
        start_halt_s = (state_q == ST_RUN) & ctl_en_s & id_halt;
    end

    // Next-state values for the EX register bundle.
    always_comb begin
        ex_valid_d      = ex_valid_q;
        ex_alu_op_d     = ex_alu_op_q;
        ex_branch_d     = ex_branch_q;
        ex_mem_read_d   = ex_mem_read_q;
        ex_mem_to_reg_d = ex_mem_to_reg_q;
        ex_mem_write_d  = ex_mem_write_q;
        ex_alu_src_d    = ex_alu_src_q;
        ex_reg_write_d  = ex_reg_write_q;
        ex_auipc_d      = ex_auipc_q;
        ex_jal_d        = ex_jal_q;
        ex_jalr_d       = ex_jalr_q;
        ex_halt_d       = ex_halt_q;
        ex_pc_d         = ex_pc_q;
        ex_rs1_data_d   = ex_rs1_data_q;
        ex_rs2_data_d   = ex_rs2_data_q;
        ex_imm_d        = ex_imm_q;
        ex_rs1_d        = ex_rs1_q;
        ex_rs2_d        = ex_rs2_q;
        ex_rd_d         = ex_rd_q;
        ex_funct3_d     = ex_funct3_q;
        ex_funct7b5_d   = ex_funct7b5_q;
        if (bubble_s) begin
            ex_valid_d      = 1'b0;
            ex_alu_op_d     = 2'b00;
            ex_branch_d     = 1'b0;
            ex_mem_read_d   = 1'b0;
            ex_mem_to_reg_d = 1'b0;
            ex_mem_write_d  = 1'b0;
            ex_alu_src_d    = 1'b0;
            ex_reg_write_d  = 1'b0;
            ex_auipc_d      = 1'b0;
            ex_jal_d        = 1'b0;
            ex_jalr_d       = 1'b0;
            ex_halt_d       = 1'b0;
            ex_pc_d         = '0;
            ex_rs1_data_d   = '0;
            ex_rs2_data_d   = '0;
            ex_imm_d        = '0;
            ex_rs1_d        = 5'd0;
            ex_rs2_d        = 5'd0;
            ex_rd_d         = 5'd0;
            ex_funct3_d     = 3'd0;
            ex_funct7b5_d   = 1'b0;
        end else if (capture_s) begin
            // Control is qualified by id_valid; data passes through untouched.
            ex_valid_d      = id_valid;
            ex_alu_op_d     = id_alu_op & {2{ctl_en_s}};
            ex_branch_d     = id_branch & ctl_en_s;
            ex_mem_read_d   = id_mem_read & ctl_en_s;
            ex_mem_to_reg_d = id_mem_to_reg & ctl_en_s;
            ex_mem_write_d  = id_mem_write & ctl_en_s;
            ex_alu_src_d    = id_alu_src & ctl_en_s;
            ex_reg_write_d  = id_reg_write & ctl_en_s;
            ex_auipc_d      = id_auipc & ctl_en_s;
            ex_jal_d        = id_jal & ctl_en_s;
            ex_jalr_d       = id_jalr & ctl_en_s;
            ex_halt_d       = id_halt & ctl_en_s;
            ex_pc_d         = id_pc;
            ex_rs1_data_d   = id_rs1_data;
            ex_rs2_data_d   = id_rs2_data;
            ex_imm_d        = id_imm;
            ex_rs1_d        = id_rs1;
            ex_rs2_d        = id_rs2;
            ex_rd_d         = id_rd;
            ex_funct3_d     = id_funct3;
            ex_funct7b5_d   = id_funct7b5;
        end else begin
            ex_valid_d      = ex_valid_q;
        end
    end

    // EX register bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q      <= 1'b0;
            ex_alu_op_q     <= 2'b00;
            ex_branch_q     <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_to_reg_q <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_alu_src_q    <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_auipc_q      <= 1'b0;
            ex_jal_q        <= 1'b0;
            ex_jalr_q       <= 1'b0;
            ex_halt_q       <= 1'b0;
            ex_pc_q         <= '0;
            ex_rs1_data_q   <= '0;
            ex_rs2_data_q   <= '0;
            ex_imm_q        <= '0;
            ex_rs1_q        <= 5'd0;
            ex_rs2_q        <= 5'd0;
            ex_rd_q         <= 5'd0;
            ex_funct3_q     <= 3'd0;
            ex_funct7b5_q   <= 1'b0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_alu_op_q     <= ex_alu_op_d;
            ex_branch_q     <= ex_branch_d;
            ex_mem_read_q   <= ex_mem_read_d;
            ex_mem_to_reg_q <= ex_mem_to_reg_d;
            ex_mem_write_q  <= ex_mem_write_d;
            ex_alu_src_q    <= ex_alu_src_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_auipc_q      <= ex_auipc_d;
            ex_jal_q        <= ex_jal_d;
            ex_jalr_q       <= ex_jalr_d;
            ex_halt_q       <= ex_halt_d;
            ex_pc_q         <= ex_pc_d;
            ex_rs1_data_q   <= ex_rs1_data_d;
            ex_rs2_data_q   <= ex_rs2_data_d;
            ex_imm_q        <= ex_imm_d;
            ex_rs1_q        <= ex_rs1_d;
            ex_rs2_q        <= ex_rs2_d;
            ex_rd_q         <= ex_rd_d;
            ex_funct3_q     <= ex_funct3_d;
            ex_funct7b5_q   <= ex_funct7b5_d;
        end
    end

    // Halt sequencer; the drain counter ignores stall so the drain time is fixed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            drain_cnt_q  <= 4'd0;
            halt_req_q   <= 1'b0;
            cpu_halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (start_halt_s) begin
                        state_q     <= ST_DRAIN;
                        drain_cnt_q <= DRAIN_INIT;
                        halt_req_q  <= 1'b1;
                    end else begin
                        halt_req_q  <= 1'b0;
                    end
                    cpu_halted_q <= 1'b0;
                end
                ST_DRAIN: begin
                    halt_req_q <= 1'b1;
                    if (drain_cnt_q == 4'd0) begin
                        state_q      <= ST_HALTED;
                        cpu_halted_q <= 1'b1;
                    end else begin
                        drain_cnt_q  <= drain_cnt_q - 4'd1;
                    end
                end
                ST_HALTED: begin
                    halt_req_q   <= 1'b1;
                    cpu_halted_q <= 1'b1;
                end
                default: begin
                    state_q      <= ST_RUN;
                    drain_cnt_q  <= 4'd0;
                    halt_req_q   <= 1'b0;
                    cpu_halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_alu_op     = ex_alu_op_q;
    assign ex_branch     = ex_branch_q;
    assign ex_mem_read   = ex_mem_read_q;
    assign ex_mem_to_reg = ex_mem_to_reg_q;
    assign ex_mem_write  = ex_mem_write_q;
    assign ex_alu_src    = ex_alu_src_q;
    assign ex_reg_write  = ex_reg_write_q;
    assign ex_auipc      = ex_auipc_q;
    assign ex_jal        = ex_jal_q;
    assign ex_jalr       = ex_jalr_q;
    assign ex_halt       = ex_halt_q;
    assign ex_pc         = ex_pc_q;
    assign ex_rs1_data   = ex_rs1_data_q;
    assign ex_rs2_data   = ex_rs2_data_q;
    assign ex_imm        = ex_imm_q;
    assign ex_rs1        = ex_rs1_q;
    assign ex_rs2        = ex_rs2_q;
    assign ex_rd         = ex_rd_q;
    assign ex_funct3     = ex_funct3_q;
    assign ex_funct7b5   = ex_funct7b5_q;
    assign halt_req      = halt_req_q;
    assign cpu_halted    = cpu_halted_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: load, stall/flush, invalid decode,
// halt drain timing and asynchronous reset during the drain.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, id_valid;
    logic [1:0]  id_alu_op;
    logic        id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src;
    logic        id_reg_write, id_auipc, id_jal, id_jalr, id_halt;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]  id_funct3;
    logic        id_funct7b5;
    logic        ex_valid;
    logic [1:0]  ex_alu_op;
    logic        ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src;
    logic        ex_reg_write, ex_auipc, ex_jal, ex_jalr, ex_halt;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic        halt_req, cpu_halted;

    int tests = 0;
    int fails = 0;

    id_ex_stage #(.XLEN(32), .HALT_DRAIN(3)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_alu_op(id_alu_op), .id_branch(id_branch), .id_mem_read(id_mem_read),
        .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
        .id_reg_write(id_reg_write), .id_auipc(id_auipc), .id_jal(id_jal), .id_jalr(id_jalr),
        .id_halt(id_halt), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
        .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_auipc(ex_auipc),
        .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_halt(ex_halt), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .halt_req(halt_req), .cpu_halted(cpu_halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 1'b0; flush = 1'b0; id_valid = 1'b0; id_alu_op = 2'b00;
        id_branch = 1'b0; id_mem_read = 1'b0; id_mem_to_reg = 1'b0; id_mem_write = 1'b0;
        id_alu_src = 1'b0; id_reg_write = 1'b0; id_auipc = 1'b0; id_jal = 1'b0;
        id_jalr = 1'b0; id_halt = 1'b0; id_pc = 32'd0; id_rs1_data = 32'd0;
        id_rs2_data = 32'd0; id_imm = 32'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
        id_funct3 = 3'd0; id_funct7b5 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #2;
        chk("rst_ex_valid", ex_valid, 32'd0);
        chk("rst_halt_req", halt_req, 32'd0);
        chk("rst_cpu_halted", cpu_halted, 32'd0);
        step();
        chk("rst_ex_rd", ex_rd, 32'd0);
        rst_n = 1'b1;

        // Basic load
        id_valid = 1'b1; id_alu_op = 2'b10; id_reg_write = 1'b1;
        id_rs1_data = 32'h0000_0005; id_rd = 5'd3;
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_funct3 = 3'd5; id_funct7b5 = 1'b1; id_jalr = 1'b1;
        step();
        chk("load_valid", ex_valid, 32'd1);
        chk("load_alu_op", ex_alu_op, 32'd2);
        chk("load_reg_write", ex_reg_write, 32'd1);
        chk("load_rs1_data", ex_rs1_data, 32'd5);
        chk("load_rd", ex_rd, 32'd3);
        chk("load_rs1", ex_rs1, 32'd1);
        chk("load_rs2", ex_rs2, 32'd2);
        chk("load_funct3", ex_funct3, 32'd5);
        chk("load_funct7b5", ex_funct7b5, 32'd1);
        chk("load_jalr", ex_jalr, 32'd1);

        // Store, then stall three cycles with changing inputs
        id_jalr = 1'b0; id_mem_write = 1'b1; id_rs2_data = 32'hAAAA_5555;
        step();
        chk("st_mem_write", ex_mem_write, 32'd1);
        chk("st_rs2_data", ex_rs2_data, 32'hAAAA_5555);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            id_mem_write = 1'b0; id_rs2_data = 32'h1234_0000 + 32'(i); id_rd = 5'd7;
            step();
            chk("stall_mem_write", ex_mem_write, 32'd1);
            chk("stall_rs2_data", ex_rs2_data, 32'hAAAA_5555);
            chk("stall_rd", ex_rd, 32'd3);
        end
        flush = 1'b1;
        step();
        chk("flush_valid", ex_valid, 32'd0);
        chk("flush_mem_write", ex_mem_write, 32'd0);
        chk("flush_rs1_data", ex_rs1_data, 32'd0);
        chk("flush_rs2_data", ex_rs2_data, 32'd0);
        chk("flush_rd", ex_rd, 32'd0);

        // Invalid decode: control forced to zero, data still captured
        clear_inputs();
        id_reg_write = 1'b1; id_branch = 1'b1; id_rs1_data = 32'd9;
        step();
        chk("inv_valid", ex_valid, 32'd0);
        chk("inv_reg_write", ex_reg_write, 32'd0);
        chk("inv_branch", ex_branch, 32'd0);
        chk("inv_rs1_data", ex_rs1_data, 32'd9);

        // Flushed halt and stalled halt never start the sequence
        clear_inputs();
        id_valid = 1'b1; id_halt = 1'b1; flush = 1'b1;
        step();
        chk("fhalt_req", halt_req, 32'd0);
        chk("fhalt_ex_halt", ex_halt, 32'd0);
        chk("fhalt_valid", ex_valid, 32'd0);
        flush = 1'b0; stall = 1'b1;
        step();
        chk("shalt_req", halt_req, 32'd0);
        chk("shalt_ex_halt", ex_halt, 32'd0);
        clear_inputs();
        id_valid = 1'b1; id_alu_op = 2'b01; id_imm = 32'hFFFF_F800; id_pc = 32'h100;
        step();
        chk("after_fh_valid", ex_valid, 32'd1);
        chk("after_fh_imm", ex_imm, 32'hFFFF_F800);
        chk("after_fh_pc", ex_pc, 32'h100);
        chk("after_fh_req", halt_req, 32'd0);

        // Halt drain, HALT_DRAIN=3; stall at T+2 and flush at T+3 must not disturb it
        clear_inputs();
        id_valid = 1'b1; id_halt = 1'b1; id_pc = 32'h200;
        step();
        chk("T_halt_req", halt_req, 32'd1);
        chk("T_ex_halt", ex_halt, 32'd1);
        chk("T_ex_valid", ex_valid, 32'd1);
        chk("T_ex_pc", ex_pc, 32'h200);
        chk("T_halted", cpu_halted, 32'd0);
        id_halt = 1'b0; id_reg_write = 1'b1; id_pc = 32'h204;
        step();
        chk("T1_halted", cpu_halted, 32'd0);
        chk("T1_ex_valid", ex_valid, 32'd0);
        chk("T1_ex_pc", ex_pc, 32'd0);
        chk("T1_halt_req", halt_req, 32'd1);
        stall = 1'b1;
        step();
        chk("T2_halted", cpu_halted, 32'd0);
        chk("T2_ex_valid", ex_valid, 32'd0);
        stall = 1'b0; flush = 1'b1;
        step();
        chk("T3_halted", cpu_halted, 32'd1);
        chk("T3_halt_req", halt_req, 32'd1);
        flush = 1'b0; stall = 1'b1;
        step();
        chk("T4_ex_valid", ex_valid, 32'd0);
        chk("T4_halted", cpu_halted, 32'd1);

        // Reset out of HALTED, then restart a halt and reset mid-drain between edges
        rst_n = 1'b0;
        #2;
        chk("rstH_halted", cpu_halted, 32'd0);
        chk("rstH_halt_req", halt_req, 32'd0);
        rst_n = 1'b1;
        clear_inputs();
        id_valid = 1'b1; id_halt = 1'b1; id_rd = 5'd9;
        step();
        chk("D_halt_req", halt_req, 32'd1);
        chk("D_ex_valid", ex_valid, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstD_halt_req", halt_req, 32'd0);
        chk("rstD_halted", cpu_halted, 32'd0);
        chk("rstD_ex_valid", ex_valid, 32'd0);
        chk("rstD_ex_halt", ex_halt, 32'd0);
        step();
        rst_n = 1'b1;
        clear_inputs();
        id_valid = 1'b1; id_mem_read = 1'b1; id_mem_to_reg = 1'b1; id_alu_src = 1'b1;
        id_auipc = 1'b1; id_jal = 1'b1; id_rd = 5'd17;
        step();
        chk("post_valid", ex_valid, 32'd1);
        chk("post_rd", ex_rd, 32'd17);
        chk("post_ctl", {ex_mem_read, ex_mem_to_reg, ex_alu_src, ex_auipc, ex_jal}, 32'h1F);
        chk("post_halt_req", halt_req, 32'd0);
        id_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("post_not_halted", cpu_halted, 32'd0);
        chk("post_req_low", halt_req, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
